// File: rtl/microwave_timer.sv
// Microwave cook-time countdown: keypad entry of MM:SS BCD digits, one-second
// decrements while the magnetron runs, and a done flag at 00:00.
module microwave_timer #(
    parameter int TICK_DIV = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clearn,
    input  logic       mag_on,
    input  logic       digit_valid,
    input  logic [3:0] digit,
    output logic [3:0] min_tens,
    output logic [3:0] min_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       timer_done,
    output logic       tick
);
    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);

    // digit_valid is a single-cycle strobe with no back-pressure: a digit is
    // taken on the edge where digit_valid=1, mag_on=0 and digit<=9, else dropped.

    logic [PW-1:0] pre, pre_n;
    logic [3:0]    mt_n, mo_n, st_n, so_n;
    logic          tick_n;
    logic          count_zero;

    assign count_zero = (min_tens == 4'd0) && (min_ones == 4'd0) &&
                        (sec_tens == 4'd0) && (sec_ones == 4'd0);

    always_comb begin
        mt_n   = min_tens;
        mo_n   = min_ones;
        st_n   = sec_tens;
        so_n   = sec_ones;
        pre_n  = pre;
        tick_n = 1'b0;
        if (!clearn) begin
            mt_n  = 4'd0;
            mo_n  = 4'd0;
            st_n  = 4'd0;
            so_n  = 4'd0;
            pre_n = '0;
        end else if (digit_valid && !mag_on && (digit <= 4'd9)) begin
            mt_n  = min_ones;
            mo_n  = sec_tens;
            st_n  = sec_ones;
            so_n  = digit;
            pre_n = '0;
        end else if (mag_on && !count_zero) begin
            if (pre == PRE_MAX) begin
                pre_n  = '0;
                tick_n = 1'b1;
                // Ripple-borrow BCD decrement; never reached at 00:00.
                if (sec_ones != 4'd0) begin
                    so_n = sec_ones - 4'd1;
                end else begin
                    so_n = 4'd9;
                    if (sec_tens != 4'd0) begin
                        st_n = sec_tens - 4'd1;
                    end else begin
                        st_n = 4'd5;
                        if (min_ones != 4'd0) begin
                            mo_n = min_ones - 4'd1;
                        end else begin
                            mo_n = 4'd9;
                            mt_n = min_tens - 4'd1;
                        end
                    end
                end
            end else begin
                pre_n = pre + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            min_tens   <= 4'd0;
            min_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            sec_ones   <= 4'd0;
            pre        <= '0;
            timer_done <= 1'b1;
            tick       <= 1'b0;
        end else begin
            min_tens   <= mt_n;
            min_ones   <= mo_n;
            sec_tens   <= st_n;
            sec_ones   <= so_n;
            pre        <= pre_n;
            timer_done <= (mt_n == 4'd0) && (mo_n == 4'd0) &&
                          (st_n == 4'd0) && (so_n == 4'd0);
            tick       <= tick_n;
        end
    end
endmodule

// File: tb/tb_microwave_timer.sv
// Directed bench for microwave_timer with TICK_DIV=4: entry, countdown,
// borrow, pause/resume and clear behaviour against hand-computed values.
module tb_microwave_timer;
  logic       clk = 1'b0;
  logic       rst;
  logic       clearn;
  logic       mag_on;
  logic       digit_valid;
  logic [3:0] digit;
  logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
  logic       timer_done;
  logic       tick;

  int n_checks = 0;
  int n_fail   = 0;
  int ticks    = 0;

  always #5 clk = ~clk;

  microwave_timer #(.TICK_DIV(4)) dut (
    .clk(clk), .rst(rst), .clearn(clearn), .mag_on(mag_on),
    .digit_valid(digit_valid), .digit(digit),
    .min_tens(min_tens), .min_ones(min_ones),
    .sec_tens(sec_tens), .sec_ones(sec_ones),
    .timer_done(timer_done), .tick(tick)
  );

  // advance one rising edge, then settle before sampling or driving
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_disp(input string tag, input logic [15:0] exp);
    chk(tag, {min_tens, min_ones, sec_tens, sec_ones}, exp);
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    step();
    digit_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clearn = 1'b1; mag_on = 1'b0; digit_valid = 1'b0; digit = 4'd0;
    step(); step();
    chk_disp("reset_digits", 16'h0000);
    chk("reset_done", 16'(timer_done), 16'd1);
    chk("reset_tick", 16'(tick), 16'd0);
    rst = 1'b0;

    key(4'd1); key(4'd3); key(4'd0);
    chk_disp("entry_0130", 16'h0130);
    chk("entry_done", 16'(timer_done), 16'd0);
    key(4'hA);
    chk_disp("entry_ignore_A", 16'h0130);

    clearn = 1'b0; step(); clearn = 1'b1;
    chk_disp("clear_idle", 16'h0000);
    chk("clear_idle_done", 16'(timer_done), 16'd1);

    key(4'd5);
    chk_disp("entry_5", 16'h0005);
    mag_on = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (tick) ticks++;
      if (i == 3) chk("run_no_tick_c3", 16'(tick), 16'd0);
      if (i == 4) begin
        chk_disp("run_0004", 16'h0004);
        chk("run_tick_c4", 16'(tick), 16'd1);
      end
      if (i == 19) chk("run_done_c19", 16'(timer_done), 16'd0);
      if (i == 20) begin
        chk_disp("run_0000_c20", 16'h0000);
        chk("run_done_c20", 16'(timer_done), 16'd1);
        chk("run_tick_c20", 16'(tick), 16'd1);
      end
    end
    chk("run_tick_count", 16'(ticks), 16'd5);
    chk_disp("run_stopped", 16'h0000);
    mag_on = 1'b0;

    key(4'd1); key(4'd0); key(4'd0);
    chk_disp("entry_0100", 16'h0100);
    mag_on = 1'b1;
    step(); step(); step(); step();
    chk_disp("borrow_0059", 16'h0059);
    mag_on = 1'b0;
    key(4'd1); key(4'd0); key(4'd0); key(4'd0);
    chk_disp("entry_1000", 16'h1000);
    mag_on = 1'b1;
    step(); step(); step(); step();
    chk_disp("borrow_0959", 16'h0959);
    mag_on = 1'b0;

    key(4'd0); key(4'd0); key(4'd1); key(4'd0);
    chk_disp("entry_0010", 16'h0010);
    mag_on = 1'b1;
    step(); step();
    mag_on = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk_disp("pause_hold", 16'h0010);
    mag_on = 1'b1; digit_valid = 1'b1; digit = 4'd7;
    step();
    digit_valid = 1'b0;
    chk_disp("resume_c1_ignore_digit", 16'h0010);
    chk("resume_c1_tick", 16'(tick), 16'd0);
    step();
    chk_disp("resume_c2_0009", 16'h0009);
    chk("resume_c2_tick", 16'(tick), 16'd1);
    mag_on = 1'b0;

    key(4'd0); key(4'd2); key(4'd0); key(4'd0);
    chk_disp("entry_0200", 16'h0200);
    mag_on = 1'b1;
    step(); step();
    clearn = 1'b0;
    step();
    clearn = 1'b1;
    chk_disp("clear_run_digits", 16'h0000);
    chk("clear_run_done", 16'(timer_done), 16'd1);
    chk("clear_run_tick", 16'(tick), 16'd0);
    mag_on = 1'b0;

    key(4'd3);
    chk_disp("entry_0003", 16'h0003);
    clearn = 1'b0; digit_valid = 1'b1; digit = 4'd4;
    step();
    clearn = 1'b1; digit_valid = 1'b0;
    chk_disp("clear_vs_entry", 16'h0000);
    chk("clear_vs_entry_done", 16'(timer_done), 16'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
